phase_softmax_sched: RTL

- Round-robin scheduler that shares one phase_softmax instance between N_REQ requesters, such as attention heads.
- Each granted job follows the same sequence:
  - the 6 relation bytes are latched;
  - the softmax lateral-inhibition state is cleared;
  - phase_softmax runs for SETTLE_CYCLES phase windows of PHASE_LEN clocks, with the scheduler generating cycle_start;
  - winner and rates are captured;
  - the result is returned over a valid/ready handshake.
- Sits between the head front-ends and the phase_softmax datapath.

---
 rtl/phase_softmax_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/phase_softmax_sched.sv
// phase_softmax_sched
//   Round-robin scheduler that time-shares a single phase_softmax datapath between
//   N_REQ requesters (e.g. attention heads). Each granted job latches the relation
//   bytes, clears the softmax, runs SETTLE_CYCLES phase windows of PHASE_LEN clocks,
//   captures winner/rates and returns them over a valid/ready handshake.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   req / ack        per-requester request (held until ack) / one-hot 1-clock grant
//   rel_in           per-requester packed relations, bytes ab,ac,ad,bc,bd,cd from bit 0
//   busy             high whenever a job is in flight (state != IDLE)
//   sm_clear         clear pulse to phase_softmax (ORed into its reset at top level)
//   sm_cycle_start   phase window boundary pulse
//   sm_rel           latched relations for the softmax, same byte order as rel_in
//   sm_winner/rates  softmax outputs
//   res_valid/ready  result handshake; res_id/res_winner/res_rates held while valid
module phase_softmax_sched #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned PHASE_LEN     = 256,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*48-1:0]      rel_in,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic                     sm_clear,
    output logic                     sm_cycle_start,
    output logic [47:0]              sm_rel,
    input  logic [2:0]               sm_winner,
    input  logic [47:0]              sm_rates,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [2:0]               res_winner,
    output logic [47:0]              res_rates
);

    localparam int unsigned IdW  = $clog2(N_REQ);
    localparam int unsigned PhW  = $clog2(PHASE_LEN);
    localparam int unsigned WinW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [PhW-1:0]  PhaseLast = PhW'(PHASE_LEN - 1);
    localparam logic [WinW-1:0] WinLast   = WinW'(SETTLE_CYCLES - 1);
    localparam logic [IdW-1:0]  IdLast    = IdW'(N_REQ - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StCapture, StResp} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [IdW-1:0]   rr_q, rr_d;
    logic [PhW-1:0]   phase_q, phase_d;
    logic [WinW-1:0]  win_q, win_d;
    logic [47:0]      sm_rel_q, sm_rel_d;
    logic [IdW-1:0]   res_id_q, res_id_d;
    logic [2:0]       res_winner_q, res_winner_d;
    logic [47:0]      res_rates_q, res_rates_d;

    logic             gnt_valid;
    logic [IdW-1:0]   gnt_idx;
    logic [47:0]      gnt_rel;
    logic             hit_hi, hit_any;
    logic [IdW-1:0]   idx_hi, idx_any;

    // Circular search: lowest requester at or above the pointer wins, otherwise the
    // lowest requester overall (the search has wrapped past N_REQ-1).
    always_comb begin
        hit_hi  = 1'b0;
        hit_any = 1'b0;
        idx_hi  = '0;
        idx_any = '0;
        for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
            if (req[j]) begin
                hit_any = 1'b1;
                idx_any = IdW'(j);
                if (IdW'(j) >= rr_q) begin
                    hit_hi = 1'b1;
                    idx_hi = IdW'(j);
                end
            end
        end
        gnt_valid = hit_any;
        gnt_idx   = hit_hi ? idx_hi : idx_any;
        gnt_rel   = '0;
        for (int j = 0; j < int'(N_REQ); j++) begin
            if (IdW'(j) == gnt_idx) begin
                gnt_rel = rel_in[j*48 +: 48];
            end
        end
    end

    // Window pulse is decoded from registered state so it can never leak outside RUN.
    assign sm_cycle_start = (state_q == StRun) && (phase_q == PhaseLast);
    assign sm_clear       = (state_q == StLoad);
    assign busy           = (state_q != StIdle);
    assign res_valid      = (state_q == StResp);
    assign ack            = ack_q;
    assign sm_rel         = sm_rel_q;
    assign res_id         = res_id_q;
    assign res_winner     = res_winner_q;
    assign res_rates      = res_rates_q;

    always_comb begin
        state_d      = state_q;
        ack_d        = '0;
        rr_d         = rr_q;
        phase_d      = phase_q;
        win_d        = win_q;
        sm_rel_d     = sm_rel_q;
        res_id_d     = res_id_q;
        res_winner_d = res_winner_q;
        res_rates_d  = res_rates_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    for (int j = 0; j < int'(N_REQ); j++) begin
                        ack_d[j] = (IdW'(j) == gnt_idx);
                    end
                    sm_rel_d = gnt_rel;
                    res_id_d = gnt_idx;
                    rr_d     = (gnt_idx == IdLast) ? '0 : gnt_idx + IdW'(1);
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                phase_d = '0;
                win_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhW'(1);
                if (sm_cycle_start) begin
                    win_d = win_q + WinW'(1);
                    if (win_q == WinLast) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                // One clock after the last window pulse: softmax rates have settled.
                res_winner_d = sm_winner;
                res_rates_d  = sm_rates;
                state_d      = StResp;
            end
            StResp: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ack_q        <= '0;
            rr_q         <= '0;
            phase_q      <= '0;
            win_q        <= '0;
            sm_rel_q     <= '0;
            res_id_q     <= '0;
            res_winner_q <= '0;
            res_rates_q  <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            rr_q         <= rr_d;
            phase_q      <= phase_d;
            win_q        <= win_d;
            sm_rel_q     <= sm_rel_d;
            res_id_q     <= res_id_d;
            res_winner_q <= res_winner_d;
            res_rates_q  <= res_rates_d;
        end
    end

endmodule
